// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM with a shared bidirectional data bus.
// Build option RAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed priority (requester 0 wins).
module ram_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req,
   input  logic [1:0]            req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr0,
   input  logic [ADDR_WIDTH-1:0] req_addr1,
   input  logic [DATA_WIDTH-1:0] req_wdata0,
   input  logic [DATA_WIDTH-1:0] req_wdata1,
   output logic [1:0]            ack,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   inout  wire  [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic                  w_take;
   logic                  w_grant_sel;
   logic                  w_drive;

   logic                  r_grant;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic [ADDR_WIDTH-1:0] w_addr_arr  [2];
   logic [DATA_WIDTH-1:0] w_wdata_arr [2];

   // Per-requester views so the grant can index the request fields directly.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         if (gi == 0) begin : g_r0
            assign w_addr_arr[gi]  = req_addr0;
            assign w_wdata_arr[gi] = req_wdata0;
         end else begin : g_r1
            assign w_addr_arr[gi]  = req_addr1;
            assign w_wdata_arr[gi] = req_wdata1;
         end
      end
   endgenerate

   assign w_take = (r_state == S_IDLE) && (req != 2'b00);

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic r_prio;  // requester that wins the next conflict

   always_comb begin
      if (req == 2'b11) begin
         w_grant_sel = r_prio;
      end else begin
         w_grant_sel = req[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= 1'b0;
      end else if (w_take) begin
         r_prio <= ~w_grant_sel;
      end
   end
`else
   assign w_grant_sel = ~req[0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   w_state_next = w_take ? S_ACCESS : S_IDLE;
         S_ACCESS: w_state_next = S_RESP;
         S_RESP:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      ack     = 2'b00;
      busy    = 1'b0;
      ram_cs  = 1'b0;
      ram_we  = 1'b0;
      ram_oe  = 1'b0;
      w_drive = 1'b0;
      case (r_state)
         S_ACCESS: begin
            busy    = 1'b1;
            ram_cs  = 1'b1;
            ram_we  = r_we;
            ram_oe  = ~r_we;
            w_drive = r_we;
         end
         S_RESP: begin
            busy         = 1'b1;
            ack[r_grant] = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Transaction fields are frozen at grant so later requester changes cannot leak in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_take) begin
         r_grant <= w_grant_sel;
         r_we    <= req_we[w_grant_sel];
         r_addr  <= w_addr_arr[w_grant_sel];
         r_wdata <= w_wdata_arr[w_grant_sel];
      end
   end

   // The RAM drives combinationally during ACCESS, so the closing edge captures valid data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if ((r_state == S_ACCESS) && !r_we) begin
         r_rdata <= ram_data;
      end
   end

   assign ram_addr = r_addr;
   assign rdata    = r_rdata;
   assign ram_data = w_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a behavioural SRAM on the shared bus, directed
// transactions push expected acks into a queue, and a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ram_arbiter;

   typedef struct {
      int         who;
      bit         rd;
      logic [7:0] data;
      int         ack_cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [1:0]  req_we;
   logic [11:0] req_addr0;
   logic [11:0] req_addr1;
   logic [7:0]  req_wdata0;
   logic [7:0]  req_wdata1;
   logic [1:0]  ack;
   logic [7:0]  rdata;
   logic        busy;
   logic [11:0] ram_addr;
   wire  [7:0]  ram_data;
   logic        ram_cs;
   logic        ram_we;
   logic        ram_oe;

   logic [7:0]  mem [0:4095];
   exp_t        sb_q [$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;

   ram_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_we     (req_we),
      .req_addr0  (req_addr0),
      .req_addr1  (req_addr1),
      .req_wdata0 (req_wdata0),
      .req_wdata1 (req_wdata1),
      .ack        (ack),
      .rdata      (rdata),
      .busy       (busy),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .ram_cs     (ram_cs),
      .ram_we     (ram_we),
      .ram_oe     (ram_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: latches writes on negedge, drives reads combinationally.
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
   end
   assign ram_data = (ram_cs && ram_oe) ? mem[ram_addr] : 8'bz;
   always @(negedge clk) begin
      if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
   end

   // Monitor: pops one expectation per ack, and checks the bus on every read cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      if (ack != 2'b00) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack actual=%b required=none cyc=%0d", ack, cyc);
         end else begin
            e = sb_q.pop_front();
            checks++;
            if (ack != (2'b01 << e.who)) begin
               failures++;
               $display("FAIL ack_who actual=%b required=%b cyc=%0d", ack, 2'b01 << e.who, cyc);
            end
            if (e.rd) begin
               checks++;
               if (rdata !== e.data) begin
                  failures++;
                  $display("FAIL rdata actual=%h required=%h cyc=%0d", rdata, e.data, cyc);
               end
            end
            if (e.ack_cyc >= 0) begin
               checks++;
               if (cyc != e.ack_cyc) begin
                  failures++;
                  $display("FAIL ack_latency actual_cyc=%0d required_cyc=%0d", cyc, e.ack_cyc);
               end
            end
            $display("ack who=%0d rd=%0d rdata=%h cyc=%0d", e.who, e.rd, rdata, cyc);
         end
      end
      if (ram_oe) begin
         checks++;
         if (ram_we || (ram_data !== mem[ram_addr])) begin
            failures++;
            $display("FAIL bus_read actual=%h we=%b required=%h addr=%h", ram_data, ram_we, mem[ram_addr], ram_addr);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
      end
   endtask

   task automatic push(input int who, input bit rd, input logic [7:0] d, input int ack_cyc);
      exp_t e;
      e.who = who; e.rd = rd; e.data = d; e.ack_cyc = ack_cyc;
      sb_q.push_back(e);
   endtask

   task automatic wait_acks(input int n, input string name);
      int got = 0;
      for (int k = 0; k < 40 && got < n; k++) begin
         @(negedge clk);
         if (ack != 2'b00) got++;
      end
      if (got < n) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=%0d required=%0d", name, got, n);
      end
   endtask

   // Issues one transaction with the arbiter idle; ends just after the edge that samples ack.
   task automatic txn(input int who, input bit we, input logic [11:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd);
      push(who, !we, exp_rd, cyc + 2);
      if (who == 0) begin
         req_addr0 = a; req_wdata0 = d;
      end else begin
         req_addr1 = a; req_wdata1 = d;
      end
      req_we[who] = we;
      req[who]    = 1'b1;
      wait_acks(1, "txn");
      @(posedge clk); #1;
      req[who] = 1'b0;
      $display("txn who=%0d we=%0d addr=%h wdata=%h", who, we, a, d);
   endtask

   initial begin
      rst_n = 1'b0; req = 2'b00; req_we = 2'b00;
      req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_ctrl", {ram_cs, ram_we, ram_oe}, 0);

      // Write then read across requesters; first request lands on the first edge after release.
      @(negedge clk); rst_n = 1'b1;
      txn(0, 1'b1, 12'h123, 8'hA5, 8'h00);
      txn(1, 1'b0, 12'h123, 8'h00, 8'hA5);

      // Boundary addresses, back-to-back reads from requester 1 (3 cycles apart via latency).
      txn(1, 1'b1, 12'hFFF, 8'h5A, 8'h00);
      txn(0, 1'b1, 12'h000, 8'hC3, 8'h00);
      txn(1, 1'b0, 12'hFFF, 8'h00, 8'h5A);
      txn(1, 1'b0, 12'h000, 8'h00, 8'hC3);

      // Address change after grant must not affect the access.
      txn(0, 1'b1, 12'h005, 8'h55, 8'h00);
      txn(0, 1'b1, 12'h006, 8'h66, 8'h00);
      push(0, 1'b1, 8'h55, cyc + 2);
      req_we[0] = 1'b0; req_addr0 = 12'h005; req[0] = 1'b1;
      @(posedge clk); #1;
      req_addr0 = 12'h006;
      chk("hold_addr", ram_addr, 12'h005);
      chk("hold_oe", ram_oe, 1);
      wait_acks(1, "hold");
      @(posedge clk); #1;
      req[0] = 1'b0;

      // Contention with both requests held; last grant before this is requester 1.
      txn(0, 1'b1, 12'h020, 8'h11, 8'h00);
      txn(1, 1'b1, 12'h021, 8'h22, 8'h00);
      req_we = 2'b00; req_addr0 = 12'h020; req_addr1 = 12'h021;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      push(0, 1'b1, 8'h11, -1); push(1, 1'b1, 8'h22, -1);
      push(0, 1'b1, 8'h11, -1); push(1, 1'b1, 8'h22, -1);
      req = 2'b11;
      wait_acks(4, "rr");
      @(posedge clk); #1;
      req = 2'b00;
`else
      push(0, 1'b1, 8'h11, -1); push(0, 1'b1, 8'h11, -1);
      push(0, 1'b1, 8'h11, -1); push(1, 1'b1, 8'h22, -1);
      req = 2'b11;
      wait_acks(3, "fixed");
      @(posedge clk); #1;
      req[0] = 1'b0;
      wait_acks(1, "fixed_loser");
      @(posedge clk); #1;
      req = 2'b00;
`endif
      chk("contention_drained", sb_q.size(), 0);

      // Reset in the middle of a write; reset is raised before the RAM's negedge latch.
      txn(0, 1'b1, 12'h010, 8'h3C, 8'h00);
      txn(1, 1'b0, 12'h010, 8'h00, 8'h3C);
      req_we[0] = 1'b1; req_addr0 = 12'h010; req_wdata0 = 8'h77; req[0] = 1'b1;
      @(posedge clk); #1;
      chk("pre_rst_cs", ram_cs, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_ack", ack, 0);
      chk("arst_rdata", rdata, 0);
      chk("arst_ctrl", {ram_cs, ram_we, ram_oe}, 0);
      req = 2'b00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      txn(1, 1'b0, 12'h010, 8'h00, 8'h3C);

      repeat (5) @(posedge clk);
      #1;
      chk("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
